// File: rtl/beep_pattern.sv
// Buzzer burst generator: on an accepted key press, plays 1..7 square-wave beeps
// separated by silent gaps, with the burst length latched from beep_num.
module beep_pattern #(
   parameter logic [15:0] TONE_DIV = 16'd25000,
   parameter logic [24:0] ON_CNT   = 25'd5_000_000,
   parameter logic [24:0] OFF_CNT  = 25'd5_000_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       key_flag,
   input  logic [2:0] beep_num,
   output logic       beep,
   output logic       busy
);

   localparam int unsigned DUR_W  = 25;
   localparam int unsigned TONE_W = 16;
   localparam int unsigned REM_W  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [DUR_W-1:0]  dur_cnt, dur_nxt;
   logic [TONE_W-1:0] tone_cnt, tone_nxt;
   logic [REM_W-1:0]  rem_cnt, rem_nxt;
   logic              beep_nxt, busy_nxt;

   logic dur_on_last, dur_off_last, tone_last;

   assign dur_on_last  = (dur_cnt == DUR_W'(ON_CNT - 25'd1));
   assign dur_off_last = (dur_cnt == DUR_W'(OFF_CNT - 25'd1));
   assign tone_last    = (tone_cnt == TONE_W'(TONE_DIV - 16'd1));

   // State, counters and outputs all update together on the rising edge
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state    <= IDLE;
         dur_cnt  <= '0;
         tone_cnt <= '0;
         rem_cnt  <= '0;
         beep     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         dur_cnt  <= dur_nxt;
         tone_cnt <= tone_nxt;
         rem_cnt  <= rem_nxt;
         beep     <= beep_nxt;
         busy     <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      dur_nxt   = dur_cnt;
      tone_nxt  = tone_cnt;
      rem_nxt   = rem_cnt;
      beep_nxt  = beep;
      busy_nxt  = busy;

      case (state)
         IDLE: begin
            beep_nxt = 1'b0;
            busy_nxt = 1'b0;
            // A zero-length request is not a burst; drop it
            if (key_flag && (beep_num != 3'd0)) begin
               state_nxt = ON;
               rem_nxt   = beep_num;
               dur_nxt   = '0;
               tone_nxt  = '0;
               beep_nxt  = 1'b1;
               busy_nxt  = 1'b1;
            end
         end

         ON: begin
            if (dur_on_last) begin
               rem_nxt  = rem_cnt - 3'd1;
               dur_nxt  = '0;
               tone_nxt = '0;
               beep_nxt = 1'b0;
               if (rem_cnt == 3'd1) begin
                  state_nxt = IDLE;
                  busy_nxt  = 1'b0;
               end else begin
                  state_nxt = OFF;
               end
            end else begin
               dur_nxt = dur_cnt + 25'd1;
               if (tone_last) begin
                  beep_nxt = ~beep;
                  tone_nxt = '0;
               end else begin
                  tone_nxt = tone_cnt + 16'd1;
               end
            end
         end

         OFF: begin
            beep_nxt = 1'b0;
            if (dur_off_last) begin
               state_nxt = ON;
               dur_nxt   = '0;
               tone_nxt  = '0;
               beep_nxt  = 1'b1;
            end else begin
               dur_nxt = dur_cnt + 25'd1;
            end
         end

         default: begin
            state_nxt = IDLE;
            beep_nxt  = 1'b0;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_beep_pattern.sv
// Directed bench for beep_pattern with short tone/on/off timing.
module tb_beep_pattern;

   localparam int ON_LEN  = 10;
   localparam int OFF_LEN = 6;

   logic       sys_clk;
   logic       sys_rst;
   logic       key_flag;
   logic [2:0] beep_num;
   logic       beep;
   logic       busy;

   int checks;
   int errors;

   beep_pattern #(
      .TONE_DIV (16'd2),
      .ON_CNT   (25'd10),
      .OFF_CNT  (25'd6)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .key_flag (key_flag),
      .beep_num (beep_num),
      .beep     (beep),
      .busy     (busy)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // Expected beep on cycle k (1-based) of a burst: 10 on cycles with a 2-high/2-low tone, then 6 off
   function automatic logic exp_beep(input int k);
      int p;
      p = (k - 1) % (ON_LEN + OFF_LEN);
      if (p < ON_LEN) return ((p % 4) < 2);
      return 1'b0;
   endfunction

   function automatic int burst_len(input int n);
      return n * ON_LEN + (n - 1) * OFF_LEN;
   endfunction

   task automatic test_reset();
      sys_rst  = 1'b1;
      beep_num = 3'd3;
      for (int i = 0; i < 3; i++) begin
         key_flag = (i != 1);
         tick();
         checks++;
         if (beep !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset cyc=%0d: beep=%b busy=%b want 0 0", i, beep, busy);
         end
      end
      key_flag = 1'b0;
      sys_rst  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (beep !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle cyc=%0d: beep=%b busy=%b want 0 0", i, beep, busy);
         end
      end
   endtask

   task automatic test_single();
      beep_num = 3'd1;
      key_flag = 1'b1;
      tick();
      key_flag = 1'b0;
      for (int k = 1; k <= burst_len(1); k++) begin
         checks++;
         if (beep !== exp_beep(k) || busy !== 1'b1) begin
            errors++;
            $display("FAIL single k=%0d: beep=%b busy=%b want %b 1", k, beep, busy, exp_beep(k));
         end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (beep !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end i=%0d: beep=%b busy=%b want 0 0", i, beep, busy);
         end
         tick();
      end
   endtask

   task automatic test_burst2();
      beep_num = 3'd2;
      key_flag = 1'b1;
      tick();
      key_flag = 1'b0;
      beep_num = 3'd0;
      for (int k = 1; k <= burst_len(2); k++) begin
         checks++;
         if (beep !== exp_beep(k) || busy !== 1'b1) begin
            errors++;
            $display("FAIL burst2 k=%0d: beep=%b busy=%b want %b 1", k, beep, busy, exp_beep(k));
         end
         tick();
      end
      checks++;
      if (beep !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL burst2_end: beep=%b busy=%b want 0 0", beep, busy);
      end
      tick();
   endtask

   task automatic test_ignore_zero();
      beep_num = 3'd0;
      key_flag = 1'b1;
      tick();
      key_flag = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (beep !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_zero i=%0d: beep=%b busy=%b want 0 0", i, beep, busy);
         end
         tick();
      end
   endtask

   task automatic test_retrigger();
      beep_num = 3'd2;
      key_flag = 1'b1;
      tick();
      key_flag = 1'b0;
      for (int k = 1; k <= burst_len(2); k++) begin
         checks++;
         if (beep !== exp_beep(k) || busy !== 1'b1) begin
            errors++;
            $display("FAIL retrigger k=%0d: beep=%b busy=%b want %b 1", k, beep, busy, exp_beep(k));
         end
         key_flag = (k == 5);
         if (k == 8) beep_num = 3'd7;
         tick();
      end
      key_flag = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (beep !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL retrigger_end i=%0d: beep=%b busy=%b want 0 0", i, beep, busy);
         end
         tick();
      end
   endtask

   task automatic test_mid_reset();
      beep_num = 3'd3;
      key_flag = 1'b1;
      tick();
      key_flag = 1'b0;
      // second OFF phase covers cycles 27..32
      for (int k = 1; k <= 28; k++) begin
         checks++;
         if (beep !== exp_beep(k) || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre k=%0d: beep=%b busy=%b want %b 1", k, beep, busy, exp_beep(k));
         end
         if (k == 28) sys_rst = 1'b1;
         tick();
      end
      checks++;
      if (beep !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_abort: beep=%b busy=%b want 0 0", beep, busy);
      end
      sys_rst = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (beep !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle i=%0d: beep=%b busy=%b want 0 0", i, beep, busy);
         end
         tick();
      end
      key_flag = 1'b1;
      tick();
      key_flag = 1'b0;
      for (int k = 1; k <= burst_len(3); k++) begin
         checks++;
         if (beep !== exp_beep(k) || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_new k=%0d: beep=%b busy=%b want %b 1", k, beep, busy, exp_beep(k));
         end
         tick();
      end
      checks++;
      if (beep !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_new_end: beep=%b busy=%b want 0 0", beep, busy);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      beep_num = 3'd1;
      key_flag = 1'b1;
      tick();
      key_flag = 1'b0;
      for (int k = 1; k <= burst_len(1); k++) begin
         checks++;
         if (beep !== exp_beep(k) || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first k=%0d: beep=%b busy=%b want %b 1", k, beep, busy, exp_beep(k));
         end
         tick();
      end
      // first idle cycle: pulse again
      checks++;
      if (beep !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap: beep=%b busy=%b want 0 0", beep, busy);
      end
      beep_num = 3'd2;
      key_flag = 1'b1;
      tick();
      key_flag = 1'b0;
      for (int k = 1; k <= burst_len(2); k++) begin
         checks++;
         if (beep !== exp_beep(k) || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second k=%0d: beep=%b busy=%b want %b 1", k, beep, busy, exp_beep(k));
         end
         tick();
      end
      checks++;
      if (beep !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: beep=%b busy=%b want 0 0", beep, busy);
      end
      tick();
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      sys_rst  = 1'b1;
      key_flag = 1'b0;
      beep_num = 3'd0;
      test_reset();
      test_single();
      test_burst2();
      test_ignore_zero();
      test_retrigger();
      test_mid_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
